// File: rtl/readout_sequencer_if.sv
// ---------------------------------------------------------------------------
// readout_sequencer_if
//   Downstream word stream of the readout sequencer.
//
//   Handshake: a word transfers on a rising clk edge where tx_valid and
//   tx_ready are both high. Once tx_valid is raised, tx_valid and tx_data
//   hold unchanged until that transfer (a pass abort is the only exception).
//   tx_data is 0 whenever tx_valid is 0.
//
//   Signals:
//     tx_valid  master -> slave   tx_data carries a header or sample word
//     tx_data   master -> slave   WIDTH-bit word
//     tx_ready  slave  -> master  downstream can take the word
// ---------------------------------------------------------------------------
interface readout_sequencer_if #(
    parameter int WIDTH = 12
);
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/readout_sequencer.sv
// ---------------------------------------------------------------------------
// readout_sequencer
//   Walks the enabled channels in ascending index order. For each channel it
//   sends a header word {4'hA, channel index}, then up to how_many sample
//   words, strobing spi_done after each one so the channel advances its
//   address. A channel ends early when its rodone_n goes low.
//
//   Ports:
//     clk, RESET_n   clock, asynchronous active-low reset
//     start, abort   begin a pass (ignored while busy) / end the current pass
//     ch_enable      per-channel include mask, sampled at start
//     how_many       words per channel, sampled at start
//     ch_data        channel k data at [k*WIDTH +: WIDTH]
//     rodone_n       per-channel finished flag (active low)
//     read_request   one-hot request to the channel being read
//     spi_done       one-cycle address-advance strobe to that channel
//     busy, done     pass in progress / one-cycle end-of-pass pulse
//     state_dbg      current FSM state encoding
//     tx             downstream word stream (master side)
// ---------------------------------------------------------------------------
module readout_sequencer #(
    parameter int NCH   = 4,
    parameter int WIDTH = 12,
    parameter int SIZE  = 12
) (
    input  logic                 clk,
    input  logic                 RESET_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCH-1:0]       ch_enable,
    input  logic [SIZE-1:0]      how_many,
    input  logic [NCH*WIDTH-1:0] ch_data,
    input  logic [NCH-1:0]       rodone_n,
    output logic [NCH-1:0]       read_request,
    output logic [NCH-1:0]       spi_done,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_dbg,
    readout_sequencer_if.master  tx
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        SETTLE = 3'd2,
        WORD   = 3'd3,
        ADV    = 3'd4,
        NEXT   = 3'd5,
        FIN    = 3'd6
    } state_t;

    state_t          state;
    logic [CW-1:0]   ch;
    logic [SIZE-1:0] word_cnt;
    logic [SIZE-1:0] how_many_q;
    logic [NCH-1:0]  en_q;

    // Lowest set bit of mask at or above index 'from'; MSB of result = found.
    function automatic logic [CW:0] pick(input logic [NCH-1:0] mask, input int from);
        logic [CW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    logic [CW:0]      first_pick;
    logic [CW:0]      next_pick;
    logic [NCH-1:0]   ch_bit;
    logic [WIDTH-1:0] ch_word;
    logic             ch_finished;

    always_comb begin
        first_pick  = pick(ch_enable, 0);
        next_pick   = pick(en_q, int'(ch) + 1);
        ch_bit      = '0;
        ch_word     = '0;
        ch_finished = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (ch == CW'(k)) begin
                ch_bit[k]   = 1'b1;
                ch_word     = ch_data[k*WIDTH +: WIDTH];
                ch_finished = ~rodone_n[k];
            end
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= IDLE;
            ch           <= '0;
            word_cnt     <= '0;
            how_many_q   <= '0;
            en_q         <= '0;
            read_request <= '0;
            spi_done     <= '0;
            tx.tx_valid  <= 1'b0;
            tx.tx_data   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done     <= 1'b0;
            spi_done <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if ((how_many != '0) && (ch_enable != '0)) begin
                            how_many_q  <= how_many;
                            en_q        <= ch_enable;
                            ch          <= first_pick[CW-1:0];
                            word_cnt    <= '0;
                            busy        <= 1'b1;
                            tx.tx_valid <= 1'b1;
                            tx.tx_data  <= {4'hA, (WIDTH-4)'(first_pick[CW-1:0])};
                            state       <= HDR;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    // Abort beats tx_ready: the pending word is dropped.
                    if (abort) begin
                        read_request <= '0;
                        tx.tx_valid  <= 1'b0;
                        tx.tx_data   <= '0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= FIN;
                    end else begin
                        case (state)
                            HDR: begin
                                if (tx.tx_ready) begin
                                    tx.tx_valid  <= 1'b0;
                                    tx.tx_data   <= '0;
                                    read_request <= ch_bit;
                                    state        <= SETTLE;
                                end
                            end
                            SETTLE: begin
                                // Channel has had a cycle of read_request; capture its word.
                                tx.tx_valid <= 1'b1;
                                tx.tx_data  <= ch_word;
                                state       <= WORD;
                            end
                            WORD: begin
                                if (tx.tx_ready) begin
                                    tx.tx_valid <= 1'b0;
                                    tx.tx_data  <= '0;
                                    word_cnt    <= word_cnt + 1'b1;
                                    spi_done    <= ch_bit;
                                    state       <= ADV;
                                end
                            end
                            ADV: begin
                                if ((word_cnt == how_many_q) || ch_finished) begin
                                    read_request <= '0;
                                    state        <= NEXT;
                                end else begin
                                    state <= SETTLE;
                                end
                            end
                            NEXT: begin
                                word_cnt <= '0;
                                if (next_pick[CW]) begin
                                    ch          <= next_pick[CW-1:0];
                                    tx.tx_valid <= 1'b1;
                                    tx.tx_data  <= {4'hA, (WIDTH-4)'(next_pick[CW-1:0])};
                                    state       <= HDR;
                                end else begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= FIN;
                                end
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_readout_sequencer
//   Directed bench for readout_sequencer (NCH=4, WIDTH=12, SIZE=12).
//   Each channel is modelled as an address counter advanced by spi_done;
//   channel k presents {k+1, addr} on its data slice, so sample n of
//   channel k is 12'h(k+1)0n.
// ---------------------------------------------------------------------------
module tb_readout_sequencer;
    localparam int NCH   = 4;
    localparam int WIDTH = 12;
    localparam int SIZE  = 12;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WORD = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic RESET_n = 1'b0;
    always #5 clk = ~clk;

    logic                 start     = 1'b0;
    logic                 abort     = 1'b0;
    logic [NCH-1:0]       ch_enable = '0;
    logic [SIZE-1:0]      how_many  = '0;
    logic [NCH*WIDTH-1:0] ch_data;
    logic [NCH-1:0]       rodone_n  = '1;
    logic [NCH-1:0]       read_request;
    logic [NCH-1:0]       spi_done;
    logic                 busy;
    logic                 done;
    logic [2:0]           state_dbg;

    readout_sequencer_if #(.WIDTH(WIDTH)) tx ();

    readout_sequencer #(.NCH(NCH), .WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk          (clk),
        .RESET_n      (RESET_n),
        .start        (start),
        .abort        (abort),
        .ch_enable    (ch_enable),
        .how_many     (how_many),
        .ch_data      (ch_data),
        .rodone_n     (rodone_n),
        .read_request (read_request),
        .spi_done     (spi_done),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg),
        .tx           (tx)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- channel model ----------------
    logic       clr        = 1'b0;
    logic       stall_mode = 1'b0;
    logic [7:0] addr [NCH];

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (clr)              addr[k] <= 8'd0;
            else if (spi_done[k]) addr[k] <= addr[k] + 8'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) ch_data[k*WIDTH +: WIDTH] = {4'(k + 1), addr[k]};
    end

    always @(posedge clk) begin
        #1;
        tx.tx_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // ---------------- scoreboard / monitor ----------------
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] got_q [$];
    int               spi_cnt [NCH];
    logic [NCH-1:0]   rr_seen;
    int               valid_cnt;
    int               stall_seen;
    logic [2:0]       done_prev;
    logic [2:0]       prev_state;
    logic             prev_valid;
    logic             prev_ready;
    logic [WIDTH-1:0] prev_data;

    always @(negedge clk) begin
        if (!RESET_n) begin
            prev_valid = 1'b0;
            prev_state = S_IDLE;
        end else if (clr) begin
            got_q.delete();
            for (int k = 0; k < NCH; k++) spi_cnt[k] = 0;
            rr_seen    = '0;
            valid_cnt  = 0;
            stall_seen = 0;
            done_prev  = 3'd7;
            prev_valid = 1'b0;
        end else begin
            check("rr_onehot", 32'($countones(read_request) <= 1), 32'd1);
            check("spi_onehot", 32'($countones(spi_done) <= 1), 32'd1);
            if (!tx.tx_valid) check("data_zero", 32'(tx.tx_data), 32'd0);
            if (prev_valid && !prev_ready) begin
                stall_seen++;
                check("stall_valid", 32'(tx.tx_valid), 32'd1);
                check("stall_data", 32'(tx.tx_data), 32'(prev_data));
            end
            if (tx.tx_valid && tx.tx_ready) got_q.push_back(tx.tx_data);
            if (tx.tx_valid) valid_cnt++;
            for (int k = 0; k < NCH; k++) if (spi_done[k]) spi_cnt[k]++;
            rr_seen = rr_seen | read_request;
            if (done) done_prev = prev_state;
            prev_state = state_dbg;
            prev_valid = tx.tx_valid;
            prev_ready = tx.tx_ready;
            prev_data  = tx.tx_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_sb();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic kick(input logic [NCH-1:0] en, input logic [SIZE-1:0] hm);
        @(posedge clk); #1;
        ch_enable = en;
        how_many  = hm;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input logic [NCH-1:0] en, input logic [SIZE-1:0] hm);
        bit seen;
        seen = 1'b0;
        kick(en, hm);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("pass_done", 32'(seen), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic build_full(input logic [NCH-1:0] en, input int hm);
        exp_q.delete();
        for (int k = 0; k < NCH; k++) begin
            if (en[k]) begin
                exp_q.push_back({4'hA, 8'(k)});
                for (int w = 0; w < hm; w++) exp_q.push_back({4'(k + 1), 8'(w)});
            end
        end
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({read_request, spi_done, tx.tx_valid, tx.tx_data, busy, done});
    endfunction

    // ---------------- directed tests ----------------
    int spi_before;

    initial begin
        #2;
        check("reset_outputs", out_vec(), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(S_IDLE));
        repeat (3) @(posedge clk);
        #3 RESET_n = 1'b1;
        repeat (2) @(posedge clk);
        check("idle_after_release", 32'({state_dbg, busy, done}), 32'({S_IDLE, 2'b00}));

        // all four channels, 3 words each
        clear_sb();
        build_full(4'b1111, 3);
        run_pass(4'b1111, 12'd3);
        compare_q("full");
        for (int k = 0; k < NCH; k++) check("full_spi_cnt", 32'(spi_cnt[k]), 32'd3);
        check("full_done_after_next", 32'(done_prev), 32'(S_NEXT));
        check("full_busy_low", 32'(busy), 32'd0);

        // sparse mask
        clear_sb();
        exp_q = '{12'hA00, 12'h100, 12'h101, 12'hA02, 12'h300, 12'h301};
        run_pass(4'b0101, 12'd2);
        compare_q("sparse");
        check("sparse_rr1", 32'(rr_seen[1]), 32'd0);
        check("sparse_rr3", 32'(rr_seen[3]), 32'd0);
        check("sparse_spi0", 32'(spi_cnt[0]), 32'd2);
        check("sparse_spi2", 32'(spi_cnt[2]), 32'd2);

        // early finish on channel 0
        clear_sb();
        exp_q = '{12'hA00, 12'h100, 12'h101, 12'hA01,
                  12'h200, 12'h201, 12'h202, 12'h203, 12'h204};
        kick(4'b0011, 12'd5);
        fork
            begin
                wait (spi_cnt[0] == 2);
                rodone_n[0] = 1'b0;
            end
            begin
                repeat (200) @(posedge clk);
            end
        join_any
        disable fork;
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check("rodone_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        rodone_n = '1;
        compare_q("rodone");
        check("rodone_spi0", 32'(spi_cnt[0]), 32'd2);
        check("rodone_spi1", 32'(spi_cnt[1]), 32'd5);

        // random downstream stalls, same stream as the full pass
        stall_mode = 1'b1;
        clear_sb();
        build_full(4'b1111, 3);
        run_pass(4'b1111, 12'd3);
        stall_mode = 1'b0;
        compare_q("stall");
        check("stall_happened", 32'(stall_seen > 0), 32'd1);

        // abort during WORD of channel 1
        clear_sb();
        kick(4'b1111, 12'd3);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (state_dbg == S_WORD && got_q.size() >= 5) break;
        end
        check("abort_reached_word", 32'(state_dbg), 32'(S_WORD));
        spi_before = spi_cnt[1];
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_state", 32'(state_dbg), 32'(S_FIN));
        check("abort_done", 32'(done), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(tx.tx_valid), 32'd0);
        check("abort_spi", 32'(spi_done), 32'd0);
        repeat (5) @(posedge clk); #1;
        check("abort_spi_cnt", 32'(spi_cnt[1]), 32'(spi_before));
        check("abort_idle", 32'({state_dbg, busy}), 32'({S_IDLE, 1'b0}));

        // reset mid-pass, then a clean pass
        clear_sb();
        kick(4'b1111, 12'd3);
        repeat (12) @(posedge clk);
        #3 RESET_n = 1'b0;
        #1;
        check("midreset_outputs", out_vec(), 32'd0);
        check("midreset_state", 32'(state_dbg), 32'(S_IDLE));
        repeat (2) @(posedge clk);
        #3 RESET_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("postreset_idle", 32'({state_dbg, busy}), 32'({S_IDLE, 1'b0}));
        clear_sb();
        build_full(4'b1111, 3);
        run_pass(4'b1111, 12'd3);
        compare_q("postreset");

        // empty pass
        clear_sb();
        run_pass(4'b1111, 12'd0);
        check("empty_valid_cnt", 32'(valid_cnt), 32'd0);
        check("empty_from_idle", 32'(done_prev), 32'(S_IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 4: number of single-channel instances serviced.
REQ-002 SHALL have parameter WIDTH, default 12: sample word width.
REQ-003 SHALL have parameter SIZE, default 12: word-count width, matching the channel how_many.
REQ-004 SHALL have port clk, input, 1: sole clock; one clock domain only.
REQ-005 SHALL have port RESET_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a readout pass.
REQ-007 SHALL have port abort, input, 1: terminate the pass in progress.
REQ-008 SHALL have port ch_enable, input, NCH: per-channel include mask, sampled at start.
REQ-009 SHALL have port how_many, input, SIZE: words per channel, sampled at start.
REQ-010 SHALL have port ch_data, input, NCH*WIDTH: channel data_out buses; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port rodone_n, input, NCH: per-channel RODONE_n; active low means the channel is finished.
REQ-012 SHALL have port tx_ready, input, 1: downstream accepts the word when tx_valid is also high.
REQ-013 SHALL have port read_request, output, NCH: one-hot per-channel read request.
REQ-014 SHALL have port spi_done, output, NCH: one-cycle per-channel address-advance strobe.
REQ-015 SHALL have port tx_valid, output, 1: tx_data is valid.
REQ-016 SHALL have port tx_data, output, WIDTH: header or sample word.
REQ-017 SHALL have port busy, output, 1: high while a pass is in progress.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at the end of a pass.

Function
REQ-019 SHALL use states IDLE, HDR, SETTLE, WORD, ADV, NEXT, FIN.
REQ-020 SHALL, in IDLE, on start=1 with how_many!=0 and ch_enable!=0, latch how_many_q and en_q, set ch to the lowest enabled index, clear word_cnt, and go to HDR.
REQ-021 SHALL, in IDLE, treat start with how_many==0 or ch_enable==0 as an empty pass: go directly to FIN.
REQ-022 SHALL, in HDR, drive tx_valid=1 and tx_data={4'hA, ch zero-extended to WIDTH-4 bits}, and hold both until tx_ready, then go to SETTLE.
REQ-023 SHALL, in SETTLE, drive read_request[ch]=1 and tx_valid=0 for exactly one cycle, then go to WORD.
REQ-024 SHALL, in WORD, drive read_request[ch]=1, tx_valid=1 and tx_data=ch_data slice ch, holding until tx_ready; on acceptance increment word_cnt and go to ADV.
REQ-025 SHALL, in ADV, drive read_request[ch]=1 and spi_done[ch]=1 for exactly one cycle.
REQ-026 SHALL, leaving ADV, go to NEXT if word_cnt==how_many_q or rodone_n[ch]==0; otherwise go to SETTLE.
REQ-027 SHALL, in NEXT, deassert read_request and clear word_cnt; if a higher enabled channel exists, set ch to it and go to HDR; otherwise go to FIN.
REQ-028 SHALL, in FIN, pulse done=1 for one cycle and return to IDLE.
REQ-029 SHALL hold busy=1 in every state except IDLE and FIN.
REQ-030 SHALL ignore start while busy.
REQ-031 SHALL, on abort=1 in any busy state, go to FIN on the next edge, with no further spi_done and tx_valid=0; abort takes priority over tx_ready in the same cycle.
REQ-032 SHALL never assert more than one read_request or spi_done bit in any cycle.
REQ-033 SHALL hold word_cnt at SIZE bits; the word_cnt==how_many_q compare is exact, so how_many=2^SIZE-1 yields that many words.
REQ-034 SHALL treat a tx_ready deassertion while tx_valid=1 as a stall: tx_data and the state are held unchanged.
REQ-035 SHALL produce registered outputs; tx_data is 0 whenever tx_valid=0.

Reset
REQ-036 SHALL, on RESET_n=0 at any time, immediately clear the state to IDLE and clear ch, word_cnt, how_many_q and en_q.
REQ-037 SHALL, on RESET_n=0, immediately drive read_request, spi_done, tx_valid, tx_data, busy and done to 0.
REQ-038 SHALL, on RESET_n release, take no action until a new start.
REQ-039 SHALL restart cleanly after a reset asserted mid-pass.

Verification
REQ-040 SHALL verify: NCH=4, ch_enable=4'b1111, how_many=3, tx_ready=1 -> 16 accepted words (per channel: header 0xA0k, then 3 samples); 3 spi_done pulses per channel; done one cycle after the last NEXT.
REQ-041 SHALL verify: ch_enable=4'b0101, how_many=2 -> headers 0xA00 and 0xA02 only; read_request[1] and read_request[3] never asserted.
REQ-042 SHALL verify: how_many=5 with rodone_n[0] driven low after the 2nd spi_done -> channel 0 stops at 2 words, then the header for channel 1 follows.
REQ-043 SHALL verify: random tx_ready stalls -> tx_data stable during each stall; word order and count unchanged versus the no-stall run.
REQ-044 SHALL verify: abort during WORD of channel 1 -> FIN next cycle; done=1; no spi_done after abort; busy=0 afterward.
REQ-045 SHALL verify: RESET_n pulsed low mid-pass -> all outputs 0 asynchronously; after release, a new start runs a full pass correctly; start with how_many=0 -> done pulse with no tx_valid.
